jts16_colmix: RTL
=================

JTS16_COLMIX -- requirements
Module: jts16_colmix

Interface
REQ-001 SHALL have parameter MODEL, default 1, meaning 0=System 16A (shadow/highlight ignored) and 1=System 16B/Out Run.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pxl_cen  input  1  pixel clock enable.
REQ-005 SHALL have ports pal_cs, cpu_addr[11:1], cpu_dout[15:0] and dswn[1:0] (inputs), giving CPU palette select, word address, write data and active-low byte write strobes.
REQ-006 SHALL have port cpu_din  output  16  palette RAM read data to the CPU.
REQ-007 SHALL have ports pal_addr  input  11  and shadow  input  1, the tile-mixer colour index and shadow flag.
REQ-008 SHALL have ports preLHBL and preLVBL  input  1  each, the undelayed blanking signals.
REQ-009 SHALL have ports red, green and blue  output  5  each, and LHBL and LVBL  output  1  each, all delayed to align with RGB.

Function
REQ-010 SHALL hold 2048x16 palette RAM, dual-ported: the CPU port reads and writes, the video port only reads.
REQ-011 SHALL write the high byte when pal_cs=1 and dswn[1]=0, write the low byte when pal_cs=1 and dswn[0]=0, and treat dswn=2'b11 as a read.
REQ-012 SHALL present cpu_din one clk after the address is presented; a same-cycle read and write to one address returns the old data.
REQ-013 SHALL sample pal_addr and shadow on a pxl_cen cycle, and RGB SHALL appear exactly 2 pxl_cen cycles later (stage 1: RAM read; stage 2: decode and shade).
REQ-014 SHALL decode entry word w as R={w[3:0],w[12]}, G={w[7:4],w[13]} and B={w[11:8],w[14]}, with w[15] as the highlight bit.
REQ-015 SHALL, when MODEL=1 and the sampled shadow=1, output each component as c>>1 (zero-fill MSB).
REQ-016 SHALL, when MODEL=0, output the component c unmodified regardless of shadow and w[15].
REQ-017 SHALL delay preLHBL and preLVBL by the same 2 pxl_cen stages, and SHALL force RGB=0 while delayed LHBL=0 or delayed LVBL=0.
REQ-018 SHALL apply a CPU write that lands between stages 1 and 2 only to pixels sampled after the write; no pixel is torn.
REQ-019 SHALL hold all pipeline registers unchanged on cycles where pxl_cen=0.

Reset
REQ-020 SHALL, while rst=1, clear red, green, blue and cpu_din to 0 and LHBL and LVBL to 0, and flush all pipeline stages to blank.
REQ-021 SHALL NOT clear palette RAM contents on reset; a mid-frame reset resumes output 2 pxl_cen cycles after release.

Configuration
REQ-022 SHALL, with JTS16_HILIGHT_EN defined, MODEL=1, shadow=0 and w[15]=1, output each component as c+((31-c)>>1), saturating at 31.
REQ-023 SHALL, without JTS16_HILIGHT_EN, ignore w[15], so that only shadow alters colour.

Structure
REQ-024 SHALL place palette-word field positions (R, G, B, LSB bits, highlight bit) and the PIPE_DLY=2 constant in shared package jts16_pkg.
REQ-025 SHALL instantiate the RAM as one sub-module, jts16_colmix_ram (dual-port, byte-enable CPU side); shading logic stays inline.

Verification
REQ-026 Bench SHALL check: CPU writes 0x7FFF to word 0x010, then pal_addr=0x010 with shadow=0 and blanking inactive -> R=G=B=31 exactly 2 pxl_cen later.
REQ-027 Bench SHALL check: same entry, shadow=1, MODEL=1 -> R=G=B=15; with MODEL=0 -> R=G=B=31.
REQ-028 Bench SHALL check: write 0x8000 to 0x020 (JTS16_HILIGHT_EN defined), shadow=0 -> R=G=B=15; without the macro -> R=G=B=0.
REQ-029 Bench SHALL check: byte write dswn=2'b10 of 0x00AB over 0x1234 -> readback 0x12AB one clk later.
REQ-030 Bench SHALL check: preLHBL=0 pulse of 4 pixels over an entry of 0x7FFF -> LHBL low and RGB=0 for exactly those 4 pixels, shifted by 2 pxl_cen.
REQ-031 Bench SHALL check: rst asserted mid-line -> all outputs 0 asynchronously; RAM readback after release is unchanged.

Source files
------------

// File: rtl/jts16_pkg.sv
// Shared constants for the System 16 colour mixer: palette word layout and pipeline depth.
package jts16_pkg;

    localparam int PIPE_DLY  = 2;
    localparam int PAL_AW    = 11;
    localparam int PAL_DW    = 16;
    localparam int PAL_WORDS = 1 << PAL_AW;
    localparam int COL_W     = 5;

    // Upper four bits of each component come from a nibble, the LSB from bits 12..14
    localparam int R_FIELD_HI = 3;
    localparam int R_FIELD_LO = 0;
    localparam int G_FIELD_HI = 7;
    localparam int G_FIELD_LO = 4;
    localparam int B_FIELD_HI = 11;
    localparam int B_FIELD_LO = 8;
    localparam int R_LSB_BIT  = 12;
    localparam int G_LSB_BIT  = 13;
    localparam int B_LSB_BIT  = 14;
    localparam int HL_BIT     = 15;

    typedef logic [COL_W-1:0] col_t;

    localparam col_t COL_MAX = '1;

    typedef struct packed {
        col_t r;
        col_t g;
        col_t b;
        logic hl;
    } pal_entry_t;

    function automatic pal_entry_t unpack_entry(input logic [PAL_DW-1:0] w);
        pal_entry_t e;
        e.r  = {w[R_FIELD_HI:R_FIELD_LO], w[R_LSB_BIT]};
        e.g  = {w[G_FIELD_HI:G_FIELD_LO], w[G_LSB_BIT]};
        e.b  = {w[B_FIELD_HI:B_FIELD_LO], w[B_LSB_BIT]};
        e.hl = w[HL_BIT];
        return e;
    endfunction

endpackage

// File: rtl/jts16_colmix_ram.sv
// Palette RAM: CPU port with byte write enables and registered read, video read port gated by pixel enable.
module jts16_colmix_ram
    import jts16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PAL_AW-1:0] cpu_addr,
    input  logic [PAL_DW-1:0] cpu_wdata,
    input  logic [1:0]        cpu_we,
    output logic [PAL_DW-1:0] cpu_rdata,
    input  logic              vid_cen,
    input  logic [PAL_AW-1:0] vid_addr,
    output logic [PAL_DW-1:0] vid_rdata
);

    logic [PAL_DW-1:0] mem [0:PAL_WORDS-1];
    logic [PAL_DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [PAL_DW-1:0] vid_rdata_q, vid_rdata_d;

    // Contents survive reset; only the read registers are cleared
    always_ff @(posedge clk) begin
        if (cpu_we[1]) mem[cpu_addr][15:8] <= cpu_wdata[15:8];
        if (cpu_we[0]) mem[cpu_addr][7:0]  <= cpu_wdata[7:0];
    end

    always_comb begin
        cpu_rdata_d = mem[cpu_addr];
        vid_rdata_d = vid_rdata_q;
        if (vid_cen) vid_rdata_d = mem[vid_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;

endmodule

// File: rtl/jts16_colmix.sv
// System 16 colour mixer: palette lookup, shadow/highlight shading and blanking, two pixel stages.
// Define JTS16_HILIGHT_EN to let palette bit 15 brighten colours on 16B/Out Run.
module jts16_colmix
    import jts16_pkg::*;
#(
    parameter int MODEL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic        pal_cs,
    input  logic [11:1] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  dswn,
    output logic [15:0] cpu_din,
    input  logic [10:0] pal_addr,
    input  logic        shadow,
    input  logic        preLHBL,
    input  logic        preLVBL,
    output logic [4:0]  red,
    output logic [4:0]  green,
    output logic [4:0]  blue,
    output logic        LHBL,
    output logic        LVBL
);

`ifdef JTS16_HILIGHT_EN
    localparam bit HILIGHT_EN = 1'b1;
`else
    localparam bit HILIGHT_EN = 1'b0;
`endif

    logic [1:0]          cpu_we;
    logic [PAL_DW-1:0]   pal_word_p1;
    pal_entry_t          ent_p1;
    logic                shadow_p1_q, shadow_p1_d;
    logic [PIPE_DLY-1:0] lhbl_sr_q, lhbl_sr_d;
    logic [PIPE_DLY-1:0] lvbl_sr_q, lvbl_sr_d;
    col_t                red_q, red_d;
    col_t                green_q, green_d;
    col_t                blue_q, blue_d;

    // Shadow halves; highlight moves halfway toward full scale and saturates
    function automatic col_t shade(input col_t c, input logic sh, input logic hl);
        col_t             half;
        logic [COL_W:0]   sum;
        half  = (COL_MAX - c) >> 1;
        sum   = {1'b0, c} + {1'b0, half};
        shade = c;
        if (MODEL == 1) begin
            if (sh)
                shade = c >> 1;
            else if (hl && HILIGHT_EN)
                shade = sum[COL_W] ? COL_MAX : sum[COL_W-1:0];
        end
    endfunction

    assign cpu_we = ~dswn & {2{pal_cs}};

    // Stage 1: palette word captured inside the RAM on the sampling pxl_cen
    jts16_colmix_ram u_ram (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_dout),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_din),
        .vid_cen   (pxl_cen),
        .vid_addr  (pal_addr),
        .vid_rdata (pal_word_p1)
    );

    // Stage 2: decode, shade and blank
    always_comb begin
        ent_p1      = unpack_entry(pal_word_p1);
        shadow_p1_d = shadow_p1_q;
        lhbl_sr_d   = lhbl_sr_q;
        lvbl_sr_d   = lvbl_sr_q;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        if (pxl_cen) begin
            shadow_p1_d = shadow;
            lhbl_sr_d   = {lhbl_sr_q[PIPE_DLY-2:0], preLHBL};
            lvbl_sr_d   = {lvbl_sr_q[PIPE_DLY-2:0], preLVBL};
            if (lhbl_sr_q[PIPE_DLY-2] && lvbl_sr_q[PIPE_DLY-2]) begin
                red_d   = shade(ent_p1.r, shadow_p1_q, ent_p1.hl);
                green_d = shade(ent_p1.g, shadow_p1_q, ent_p1.hl);
                blue_d  = shade(ent_p1.b, shadow_p1_q, ent_p1.hl);
            end else begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_p1_q <= 1'b0;
            lhbl_sr_q   <= '0;
            lvbl_sr_q   <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            shadow_p1_q <= shadow_p1_d;
            lhbl_sr_q   <= lhbl_sr_d;
            lvbl_sr_q   <= lvbl_sr_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign LHBL  = lhbl_sr_q[PIPE_DLY-1];
    assign LVBL  = lvbl_sr_q[PIPE_DLY-1];

endmodule
